lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 195 +++++++++++++++++++
 tb/tb_lfsr_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: tracks an 8-bit pseudo-random stream and reports lock status
// and prediction errors.
// Each sample is checked against predict(p) = {p[6:0], ~(p[7]^p[3]^p[2])}.
//
// Two states:
//   HUNT   - the checker looks for LOCK_COUNT consecutive correct predictions.
//   LOCKED - the prediction free-runs from its own previous value (flywheel),
//            and every mismatching sample raises a one-cycle error pulse.
//            LOSS_COUNT consecutive mismatches send the checker back to HUNT.
//
// Optional feature:
//   LFSR_CHECKER_STUCK_DETECT_EN - when defined, 'stuck' rises once four
//   consecutive valid samples carry the same value. This stream never
//   repeats a value, so a repeat always means a fault. When the macro is
//   not defined, 'stuck' is tied low.
//
// All outputs are registered. The response to a sample appears on the cycle
// after that sample is accepted. Reset is synchronous and active-high.

module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        clear_count,
  output logic        locked,
  output logic        error,
  output logic [15:0] err_count,
  output logic        stuck
);

  // The counters only need to hold values up to (limit - 1). The state
  // changes on the sample that would make them reach the limit.
  localparam int HUNT_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int MISS_W = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;
  localparam logic [HUNT_W-1:0] HUNT_LAST = HUNT_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_COUNT - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          prev_q, prev_d;
  logic                have_prev_q, have_prev_d;
  logic [HUNT_W-1:0]   hunt_cnt_q, hunt_cnt_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic                error_q, error_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [7:0]          expected;
  logic                match;
  logic                count_err;

  // Next value of the stream, given the current value.
  function automatic logic [7:0] predict(input logic [7:0] p);
    return {p[6:0], ~(p[7] ^ p[3] ^ p[2])};
  endfunction

  // State register and datapath registers. Reset returns the checker to a
  // cold HUNT, and reset takes priority over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      hunt_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      hunt_cnt_q  <= hunt_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state logic for acquisition and tracking. Cycles with in_valid low
  // leave every register unchanged. The error pulse drops back to 0.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    hunt_cnt_d  = hunt_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    error_d     = 1'b0;
    count_err   = 1'b0;
    expected    = predict(prev_q);
    match       = (in_data == expected);

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          // In HUNT, every sample becomes the new reference, whether it
          // matched the prediction or not.
          prev_d      = in_data;
          have_prev_d = 1'b1;
          if (have_prev_q) begin
            if (match) begin
              if (hunt_cnt_q == HUNT_LAST) begin
                state_d    = LOCKED;
                hunt_cnt_d = '0;
                miss_cnt_d = '0;
              end else begin
                hunt_cnt_d = hunt_cnt_q + HUNT_W'(1);
              end
            end else begin
              hunt_cnt_d = '0;
            end
          end
        end

        LOCKED: begin
          // The flywheel always advances from its own prediction, so a
          // corrupted sample does not throw off later predictions.
          prev_d = expected;
          if (match) begin
            miss_cnt_d = '0;
          end else begin
            error_d   = 1'b1;
            count_err = 1'b1;
            if (miss_cnt_q == MISS_LAST) begin
              // Lock is lost. The failing sample becomes the first
              // reference for the next HUNT.
              state_d     = HUNT;
              hunt_cnt_d  = '0;
              miss_cnt_d  = '0;
              prev_d      = in_data;
              have_prev_d = 1'b1;
            end else begin
              miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end

    // Saturating error counter. If clear_count and an increment happen in
    // the same cycle, the clear wins.
    err_count_d = err_count_q;
    if (clear_count) begin
      err_count_d = '0;
    end else if (count_err && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign error     = error_q;
  assign err_count = err_count_q;

`ifdef LFSR_CHECKER_STUCK_DETECT_EN
  logic [7:0] last_q;
  logic [2:0] run_q;
  logic       stuck_q;

  // Repeat detector, independent of HUNT/LOCKED. run_q is the length of the
  // current run of identical samples, saturating at 4. A value of 0 means
  // no sample has been seen since reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q  <= '0;
      run_q   <= '0;
      stuck_q <= 1'b0;
    end else if (in_valid) begin
      last_q <= in_data;
      if ((run_q != 3'd0) && (in_data == last_q)) begin
        if (run_q != 3'd4) begin
          run_q <= run_q + 3'd1;
        end
        stuck_q <= (run_q >= 3'd3);
      end else begin
        run_q   <= 3'd1;
        stuck_q <= 1'b0;
      end
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: testbench for lfsr_checker, checked by a scoreboard.
//
// Instance 0 uses the default parameters. It runs the directed scenarios
// and a randomized phase.
// Instance 1 uses a very large LOSS_COUNT, so it can stay locked through a
// long run of errors. This drives err_count up to its saturation value.
//
// For every stimulus cycle, the bench model pushes the expected outputs into
// a queue. A separate monitor pops one entry per clock and compares it with
// the outputs of the device under test.

module tb_lfsr_checker;

  localparam int LOCK_N  = 4;
  localparam int LOSS_N  = 3;
  localparam int BIG_LOSS = 70000;

  typedef struct packed {
    logic        locked;
    logic        error;
    logic [15:0] err_count;
    logic        stuck;
  } obs_t;

  logic        clock = 1'b0;
  logic        rst [2];
  logic        vld [2];
  logic [7:0]  dat [2];
  logic        clr [2];
  logic        lk  [2];
  logic        er  [2];
  logic [15:0] ec  [2];
  logic        st  [2];

  int checks = 0;
  int errors = 0;

  obs_t  expq0[$];
  obs_t  expq1[$];
  string tagq0[$];
  string tagq1[$];

  // Model state for each instance, kept as plain integers.
  int         m_locked [2];
  int         m_have   [2];
  int         m_hunt   [2];
  int         m_miss   [2];
  int         m_err    [2];
  int         m_run    [2];
  logic [7:0] m_prev   [2];
  logic [7:0] m_last   [2];
  int         loss_lim [2];

  logic [7:0] stream;
  logic [7:0] last_sent;

  always #5 clock = ~clock;

  lfsr_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) u_main (
    .clock(clock), .reset(rst[0]), .in_valid(vld[0]), .in_data(dat[0]),
    .clear_count(clr[0]), .locked(lk[0]), .error(er[0]),
    .err_count(ec[0]), .stuck(st[0])
  );

  lfsr_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(BIG_LOSS)) u_sat (
    .clock(clock), .reset(rst[1]), .in_valid(vld[1]), .in_data(dat[1]),
    .clear_count(clr[1]), .locked(lk[1]), .error(er[1]),
    .err_count(ec[1]), .stuck(st[1])
  );

  function automatic logic [7:0] predict(input logic [7:0] p);
    return {p[6:0], ~(p[7] ^ p[3] ^ p[2])};
  endfunction

  // Reference behaviour, applied once per clock for one instance.
  task automatic model_step(input int i, input logic v, input logic [7:0] d,
                            input logic c, input logic r, output obs_t e);
    logic       pulse;
    logic [7:0] want;
    pulse = 1'b0;
    if (r) begin
      m_locked[i] = 0; m_have[i] = 0; m_hunt[i] = 0; m_miss[i] = 0;
      m_err[i] = 0; m_run[i] = 0; m_prev[i] = 8'h00; m_last[i] = 8'h00;
    end else begin
      if (v) begin
        want = predict(m_prev[i]);
        if (m_locked[i] != 0) begin
          m_prev[i] = want;
          if (d != want) begin
            pulse = 1'b1;
            if (m_err[i] < 65535) m_err[i] = m_err[i] + 1;
            m_miss[i] = m_miss[i] + 1;
            if (m_miss[i] == loss_lim[i]) begin
              m_locked[i] = 0; m_hunt[i] = 0; m_miss[i] = 0;
              m_prev[i] = d; m_have[i] = 1;
            end
          end else begin
            m_miss[i] = 0;
          end
        end else if (m_have[i] == 0) begin
          m_prev[i] = d;
          m_have[i] = 1;
        end else begin
          m_hunt[i] = (d == want) ? m_hunt[i] + 1 : 0;
          m_prev[i] = d;
          if (m_hunt[i] == LOCK_N) begin
            m_locked[i] = 1; m_hunt[i] = 0; m_miss[i] = 0;
          end
        end
        m_run[i]  = (m_run[i] > 0 && d == m_last[i]) ? m_run[i] + 1 : 1;
        m_last[i] = d;
      end
      if (c) m_err[i] = 0;
    end
    e.locked    = (m_locked[i] != 0);
    e.error     = pulse;
    e.err_count = 16'(m_err[i]);
`ifdef LFSR_CHECKER_STUCK_DETECT_EN
    e.stuck     = (m_run[i] >= 4);
`else
    e.stuck     = 1'b0;
`endif
  endtask

  // Drives one clock of stimulus. sel picks the instance (2 = both); the
  // other instance is kept idle. The expected outputs are pushed for both.
  task automatic applyStimulus(input int sel, input logic v, input logic [7:0] d,
                               input logic c, input logic r, input string tag);
    obs_t e;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      if (sel == i || sel == 2) begin
        rst[i] = r; vld[i] = v; dat[i] = d; clr[i] = c;
      end else begin
        rst[i] = 1'b0; vld[i] = 1'b0; dat[i] = 8'($urandom); clr[i] = 1'b0;
      end
      model_step(i, vld[i], dat[i], clr[i], rst[i], e);
      if (i == 0) begin
        expq0.push_back(e); tagq0.push_back(tag);
      end else begin
        expq1.push_back(e); tagq1.push_back(tag);
      end
    end
  endtask

  task automatic checkOutput(input int i, input obs_t exp_o, input string tag);
    obs_t act;
    act = {lk[i], er[i], ec[i], st[i]};
    checks++;
    if (act !== exp_o) begin
      errors++;
      $display("[TB] FAIL %s inst%0d: got locked=%b error=%b err_count=%h stuck=%b, expected locked=%b error=%b err_count=%h stuck=%b",
               tag, i, act.locked, act.error, act.err_count, act.stuck,
               exp_o.locked, exp_o.error, exp_o.err_count, exp_o.stuck);
    end
  endtask

  // Monitor: one expected entry per instance is due just after each edge.
  always @(posedge clock) begin
    #1;
    if (expq0.size() > 0) checkOutput(0, expq0.pop_front(), tagq0.pop_front());
    if (expq1.size() > 0) checkOutput(1, expq1.pop_front(), tagq1.pop_front());
  end

  // Sends five consecutive stream values starting at seed, then points
  // 'stream' at the next value the flywheel will expect.
  task automatic acquire(input int sel, input logic [7:0] seed, input string tag);
    logic [7:0] d;
    d = seed;
    repeat (5) begin
      applyStimulus(sel, 1'b1, d, 1'b0, 1'b0, tag);
      d = predict(d);
    end
    stream = d;
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) applyStimulus(0, 1'b0, 8'($urandom), 1'b0, 1'b0, tag);
  endtask

  initial begin
    int roll;
    logic [7:0] d;
    loss_lim[0] = LOSS_N;
    loss_lim[1] = BIG_LOSS;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; vld[i] = 1'b0; dat[i] = 8'h00; clr[i] = 1'b0;
    end

    applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b1, "reset_state");
    applyStimulus(2, 1'b1, 8'h3C, 1'b1, 1'b1, "reset_overrides");

    // First acquisition from 00, then one idle cycle with lock visible.
    acquire(0, 8'h00, "acquire");
    idle(1, "lock_visible");

    // A single corrupted sample: one pulse, and the flywheel keeps the
    // following predictions correct.
    applyStimulus(0, 1'b1, stream, 1'b0, 1'b0, "locked_good"); stream = predict(stream);
    applyStimulus(0, 1'b1, stream ^ 8'h01, 1'b0, 1'b0, "single_error"); stream = predict(stream);
    applyStimulus(0, 1'b1, stream, 1'b0, 1'b0, "after_error_a"); stream = predict(stream);
    applyStimulus(0, 1'b1, stream, 1'b0, 1'b0, "after_error_b"); stream = predict(stream);
    idle(3, "idle_gap_locked");

    // Three wrong samples in a row drop lock; then reacquire.
    repeat (3) applyStimulus(0, 1'b1, 8'h55, 1'b0, 1'b0, "lose_lock");
    acquire(0, 8'h00, "relock");
    idle(1, "relock_visible");

    // Repeated value, then a different one.
    repeat (4) applyStimulus(0, 1'b1, 8'h5A, 1'b0, 1'b0, "stuck_run");
    idle(3, "stuck_hold");
    applyStimulus(0, 1'b1, 8'h5B, 1'b0, 1'b0, "stuck_clear");

    // Reset while locked, with errors already counted.
    acquire(0, 8'h21, "pre_reset_lock");
    applyStimulus(0, 1'b1, ~stream, 1'b0, 1'b0, "pre_reset_err");
    applyStimulus(0, 1'b1, 8'h00, 1'b0, 1'b1, "mid_lock_reset");
    applyStimulus(0, 1'b1, 8'h40, 1'b0, 1'b0, "post_reset_first");
    idle(3, "idle_gap_hunt");
    d = predict(8'h40);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1'b1, d, 1'b0, 1'b0, "gapped_acquire");
      d = predict(d);
      idle(3, "gapped_idle");
    end

    // Randomized traffic.
    last_sent = 8'h00;
    for (int k = 0; k < 600; k++) begin
      roll = int'($urandom_range(0, 99));
      if (roll < 70)      d = predict(last_sent);
      else if (roll < 80) d = last_sent;
      else                d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        applyStimulus(0, 1'b1, d, ($urandom_range(0, 29) == 0),
                      ($urandom_range(0, 99) == 0), "random");
        last_sent = d;
      end else begin
        applyStimulus(0, 1'b0, d, ($urandom_range(0, 29) == 0), 1'b0, "random_idle");
      end
    end

    // Saturation on the second instance.
    acquire(1, 8'h00, "sat_acquire");
    for (int k = 0; k < 65535; k++) begin
      applyStimulus(1, 1'b1, stream ^ 8'hFF, 1'b0, 1'b0, "sat_ramp");
      stream = predict(stream);
    end
    applyStimulus(1, 1'b1, stream ^ 8'hFF, 1'b0, 1'b0, "sat_hold"); stream = predict(stream);
    applyStimulus(1, 1'b1, stream ^ 8'hFF, 1'b1, 1'b0, "sat_clear_wins"); stream = predict(stream);
    applyStimulus(1, 1'b1, stream, 1'b0, 1'b0, "sat_after_clear");

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int k = 0; k < 5 && (expq0.size() + expq1.size()) > 0; k++) @(posedge clock);
    #2;
    checks++;
    if ((expq0.size() + expq1.size()) != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d entries left, expected 0", expq0.size() + expq1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
